neuron_layer_train_seq: RTL and testbench

- Sequencer that sits between a sample source and one 45-neuron learn layer of width N. It can also drive any same-shape layer.
- Accepts one training/inference sample per handshake and drives the layer's `in`, `expected_out`, `valid` and `learn` with correct timing.
- Waits for the layer outputs to settle, captures them, scores them against the expected vector, and returns a result over a valid/ready handshake.
- One sample is in flight at a time.

---
 rtl/neuron_layer_train_seq.sv | 179 +++++++++++++++++
 tb/tb_neuron_layer_train_seq.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_layer_train_seq.sv
// Sample sequencer for one learn layer: drive, settle, capture, score, report.
// Build option NEURON_SEQ_ERR_ACCUM_EN adds err_sum/err_clear (saturating error sum).
module neuron_layer_train_seq #(
    parameter int N      = 16,
    parameter int M      = 45,
    parameter int SETTLE = 2,
    parameter int TOL    = 8,
    parameter int W      = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [N*W-1:0]           s_in,
    input  logic [M*W-1:0]           s_expected,
    input  logic                     s_learn,
    input  logic                     learn_enable,
    output logic [N*W-1:0]           layer_in,
    output logic [M*W-1:0]           layer_expected,
    output logic                     layer_valid,
    output logic                     layer_learn,
    input  logic [M*W-1:0]           layer_out,
    output logic                     r_valid,
    input  logic                     r_ready,
    output logic [M*W-1:0]           r_out,
    output logic [$clog2(M+1)-1:0]   r_miss,
    output logic                     r_learned,
    output logic                     busy
`ifdef NEURON_SEQ_ERR_ACCUM_EN
   ,input  logic                     err_clear,
    output logic [31:0]              err_sum
`endif
);

    localparam int MW = $clog2(M + 1);
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    generate
        if (SETTLE < 1) begin : g_bad_settle
            $error("SETTLE must be at least 1");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_INFER,
        S_SETTLE,
        S_LEARN,
        S_REPORT
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic            r_lflag;
    logic [W:0]      w_diff [M];
    logic [MW-1:0]   w_miss;
    logic            w_capture;

    // Unsigned |out - expected| per neuron, one bit wider so it never wraps
    for (genvar j = 0; j < M; j++) begin : g_diff
        logic [W-1:0] w_o;
        logic [W-1:0] w_e;
        assign w_o = layer_out[j*W +: W];
        assign w_e = layer_expected[j*W +: W];
        assign w_diff[j] = (w_o >= w_e) ? ({1'b0, w_o} - {1'b0, w_e})
                                        : ({1'b0, w_e} - {1'b0, w_o});
    end

    always_comb begin
        w_miss = '0;
        for (int j = 0; j < M; j++) begin
            if (w_diff[j] > (W+1)'(TOL)) begin
                w_miss = w_miss + MW'(1);
            end
        end
    end

    assign w_capture = (r_state == S_SETTLE) && (r_cnt == '0);
    assign busy      = (r_state != S_IDLE);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_cnt          <= '0;
            r_lflag        <= 1'b0;
            s_ready        <= 1'b0;
            layer_in       <= '0;
            layer_expected <= '0;
            layer_valid    <= 1'b0;
            layer_learn    <= 1'b0;
            r_valid        <= 1'b0;
            r_out          <= '0;
            r_miss         <= '0;
            r_learned      <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    s_ready <= 1'b1;
                    if (s_valid && s_ready) begin
                        layer_in       <= s_in;
                        layer_expected <= s_expected;
                        r_lflag        <= s_learn & learn_enable;
                        s_ready        <= 1'b0;
                        layer_valid    <= 1'b1;
                        r_state        <= S_INFER;
                    end
                end
                S_INFER: begin
                    layer_valid <= 1'b0;
                    layer_learn <= 1'b0;
                    r_cnt       <= CW'(SETTLE - 1);
                    r_state     <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (r_cnt == '0) begin
                        r_out  <= layer_out;
                        r_miss <= w_miss;
                        if (r_lflag) begin
                            layer_valid <= 1'b1;
                            layer_learn <= 1'b1;
                            r_state     <= S_LEARN;
                        end else begin
                            r_valid <= 1'b1;
                            r_state <= S_REPORT;
                        end
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                S_LEARN: begin
                    layer_valid <= 1'b0;
                    layer_learn <= 1'b0;
                    r_learned   <= 1'b1;
                    r_valid     <= 1'b1;
                    r_state     <= S_REPORT;
                end
                S_REPORT: begin
                    // s_ready rises with the handshake: next accept is one cycle later
                    if (r_valid && r_ready) begin
                        r_valid   <= 1'b0;
                        r_learned <= 1'b0;
                        s_ready   <= 1'b1;
                        r_state   <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef NEURON_SEQ_ERR_ACCUM_EN
    logic [31:0] w_err_add;
    logic [32:0] w_err_next;

    always_comb begin
        w_err_add = '0;
        for (int j = 0; j < M; j++) begin
            w_err_add = w_err_add + 32'(w_diff[j]);
        end
    end

    assign w_err_next = {1'b0, err_sum} + {1'b0, w_err_add};

    // Clear wins over a same-cycle capture
    always_ff @(posedge clock) begin
        if (reset || err_clear) begin
            err_sum <= '0;
        end else if (w_capture) begin
            err_sum <= w_err_next[32] ? '1 : w_err_next[31:0];
        end
    end
`else
    logic w_unused;
    assign w_unused = w_capture;
`endif

endmodule

// File: tb/tb_neuron_layer_train_seq.sv
// Bench for neuron_layer_train_seq: directed table, backpressure, abort and random samples.
module tb_neuron_layer_train_seq;

    localparam int N      = 16;
    localparam int M      = 45;
    localparam int SETTLE = 2;
    localparam int TOL    = 8;
    localparam int W      = 8;
    localparam int MW     = $clog2(M + 1);
    localparam int VW     = M * W;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic            s_valid = 1'b0;
    logic            s_ready;
    logic [N*W-1:0]  s_in = '0;
    logic [M*W-1:0]  s_expected = '0;
    logic            s_learn = 1'b0;
    logic            learn_enable = 1'b0;
    logic [N*W-1:0]  layer_in;
    logic [M*W-1:0]  layer_expected;
    logic            layer_valid;
    logic            layer_learn;
    logic [M*W-1:0]  layer_out = '0;
    logic            r_valid;
    logic            r_ready = 1'b0;
    logic [M*W-1:0]  r_out;
    logic [MW-1:0]   r_miss;
    logic            r_learned;
    logic            busy;
`ifdef NEURON_SEQ_ERR_ACCUM_EN
    logic            err_clear = 1'b0;
    logic [31:0]     err_sum;
    longint          err_model = 0;
`endif

    neuron_layer_train_seq #(
        .N(N), .M(M), .SETTLE(SETTLE), .TOL(TOL), .W(W)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .s_in           (s_in),
        .s_expected     (s_expected),
        .s_learn        (s_learn),
        .learn_enable   (learn_enable),
        .layer_in       (layer_in),
        .layer_expected (layer_expected),
        .layer_valid    (layer_valid),
        .layer_learn    (layer_learn),
        .layer_out      (layer_out),
        .r_valid        (r_valid),
        .r_ready        (r_ready),
        .r_out          (r_out),
        .r_miss         (r_miss),
        .r_learned      (r_learned),
        .busy           (busy)
`ifdef NEURON_SEQ_ERR_ACCUM_EN
       ,.err_clear      (err_clear),
        .err_sum        (err_sum)
`endif
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int n_tests = 0;
    int n_fail  = 0;

    int in_a  [N];
    int exp_a [M];
    int out_a [M];

    typedef struct {
        bit lrn;
        bit le;
        int n_over;
        int n_eq;
        int exp_miss;
        bit exp_learned;
    } vec_t;

    task automatic check(input string nm, input logic [VW-1:0] act,
                         input logic [VW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [N*W-1:0] pack_n();
        logic [N*W-1:0] v;
        for (int j = 0; j < N; j++) v[j*W +: W] = W'(in_a[j]);
        return v;
    endfunction

    function automatic logic [M*W-1:0] pack_m(input int a [M]);
        logic [M*W-1:0] v;
        for (int j = 0; j < M; j++) v[j*W +: W] = W'(a[j]);
        return v;
    endfunction

    function automatic int ref_miss();
        int c = 0;
        for (int j = 0; j < M; j++) begin
            int d = out_a[j] - exp_a[j];
            if (d < 0) d = -d;
            if (d > TOL) c++;
        end
        return c;
    endfunction

    function automatic int ref_err();
        int s = 0;
        for (int j = 0; j < M; j++) begin
            int d = out_a[j] - exp_a[j];
            if (d < 0) d = -d;
            s += d;
        end
        return s;
    endfunction

    function automatic void build_directed(input int n_over, input int n_eq);
        for (int j = 0; j < N; j++) in_a[j] = int'($urandom_range(0, 255));
        for (int j = 0; j < M; j++) begin
            int d;
            exp_a[j] = 100 + int'($urandom_range(0, 50));
            if (j < n_over) d = TOL + 1;
            else if (j < n_over + n_eq) d = TOL;
            else d = int'($urandom_range(0, TOL));
            out_a[j] = (j % 2 == 1) ? exp_a[j] + d : exp_a[j] - d;
        end
    endfunction

    function automatic void build_random();
        for (int j = 0; j < N; j++) in_a[j] = int'($urandom_range(0, 255));
        for (int j = 0; j < M; j++) begin
            int o;
            exp_a[j] = int'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) begin
                o = int'($urandom_range(0, 255));
            end else begin
                o = exp_a[j] + int'($urandom_range(0, 2*TOL + 2)) - (TOL + 1);
            end
            if (o < 0) o = 0;
            if (o > 255) o = 255;
            out_a[j] = o;
        end
    endfunction

    task automatic do_sample(input bit lrn, input bit le, input int exp_miss,
                             input bit exp_lf, input int rdelay,
                             input bit disturb, input bit early);
        logic [VW-1:0] exp_out;
        logic [15:0]   vld_mask, lrn_mask, vld_mask_e, lrn_mask_e;
        int            w, rk;
        bit            bad, hold_ok;
        exp_out      = pack_m(out_a);
        s_in         = pack_n();
        s_expected   = pack_m(exp_a);
        layer_out    = exp_out;
        s_learn      = lrn;
        learn_enable = le;
        s_valid      = 1'b1;
        r_ready      = early;
        w = 0;
        while (!s_ready && w < 20) begin
            @(posedge clock); #1;
            w++;
        end
        if (!s_ready) begin
            check("accept_wait", VW'(s_ready), VW'(1));
            s_valid = 1'b0;
            return;
        end
        @(posedge clock); #1;
        s_valid      = 1'b0;
        learn_enable = ~le;
        check("layer_in", VW'(layer_in), VW'(pack_n()));
        check("layer_expected", layer_expected, pack_m(exp_a));
        vld_mask = '0;
        lrn_mask = '0;
        rk  = 0;
        bad = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            vld_mask[k] = layer_valid;
            lrn_mask[k] = layer_learn;
            if (layer_learn && !layer_valid) bad = 1'b1;
            if (r_valid) begin
                rk = k;
                break;
            end
            @(posedge clock); #1;
        end
        vld_mask_e = 16'b10;
        lrn_mask_e = '0;
        if (exp_lf) begin
            vld_mask_e[SETTLE+2] = 1'b1;
            lrn_mask_e[SETTLE+2] = 1'b1;
        end
        check("latency", VW'(rk), VW'(SETTLE + 2 + int'(exp_lf)));
        check("valid_pulses", VW'(vld_mask), VW'(vld_mask_e));
        check("learn_pulses", VW'(lrn_mask), VW'(lrn_mask_e));
        check("learn_implies_valid", VW'(bad), VW'(0));
        check("r_out", r_out, exp_out);
        check("r_miss", VW'(r_miss), VW'(exp_miss));
        check("r_learned", VW'(r_learned), VW'(exp_lf));
`ifdef NEURON_SEQ_ERR_ACCUM_EN
        err_model += longint'(ref_err());
        if (err_model > 64'hFFFF_FFFF) err_model = 64'hFFFF_FFFF;
        check("err_sum", VW'(err_sum), VW'(err_model));
`endif
        if (rdelay > 0) begin
            r_ready = 1'b0;
            hold_ok = 1'b1;
            for (int i = 0; i < rdelay; i++) begin
                if (disturb) begin
                    for (int j = 0; j < M; j++) layer_out[j*W +: W] = W'($urandom);
                    for (int j = 0; j < N; j++) s_in[j*W +: W] = W'($urandom);
                    s_valid = 1'b1;
                end
                @(posedge clock); #1;
                if (r_out !== exp_out || r_miss !== MW'(exp_miss) ||
                    r_valid !== 1'b1 || s_ready !== 1'b0) hold_ok = 1'b0;
            end
            check("hold", VW'(hold_ok), VW'(1));
        end
        r_ready = 1'b1;
        @(posedge clock); #1;
        r_ready = 1'b0;
        check("post_handshake", VW'({r_valid, r_learned, busy, s_ready}), VW'(4'b0001));
    endtask

    task automatic abort_run(input int cyc);
        bit rv_seen;
        build_random();
        s_in       = pack_n();
        s_expected = pack_m(exp_a);
        layer_out  = pack_m(out_a);
        s_learn    = 1'b0;
        r_ready    = 1'b0;
        s_valid    = 1'b1;
        for (int w = 0; w < 20 && !s_ready; w++) begin
            @(posedge clock); #1;
        end
        @(posedge clock); #1;
        s_valid = 1'b0;
        repeat (cyc) begin
            @(posedge clock); #1;
        end
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        check("abort_cleared",
              VW'({layer_valid, layer_learn, r_valid, busy, s_ready}), VW'(0));
`ifdef NEURON_SEQ_ERR_ACCUM_EN
        err_model = 0;
        check("abort_err_sum", VW'(err_sum), VW'(0));
`endif
        @(posedge clock); #1;
        check("abort_idle", VW'({s_ready, busy, r_valid}), VW'(3'b100));
        rv_seen = 1'b0;
        repeat (6) begin
            @(posedge clock); #1;
            rv_seen |= r_valid;
        end
        check("abort_no_result", VW'(rv_seen), VW'(0));
    endtask

    vec_t tbl [6];

    initial begin
        tbl[0] = '{lrn: 1'b0, le: 1'b0, n_over: 0, n_eq: 0, exp_miss: 0, exp_learned: 1'b0};
        tbl[1] = '{lrn: 1'b1, le: 1'b1, n_over: 3, n_eq: 1, exp_miss: 3, exp_learned: 1'b1};
        tbl[2] = '{lrn: 1'b1, le: 1'b0, n_over: 2, n_eq: 2, exp_miss: 2, exp_learned: 1'b0};
        tbl[3] = '{lrn: 1'b0, le: 1'b1, n_over: 5, n_eq: 0, exp_miss: 5, exp_learned: 1'b0};
        tbl[4] = '{lrn: 1'b1, le: 1'b1, n_over: M, n_eq: 0, exp_miss: M, exp_learned: 1'b1};
        tbl[5] = '{lrn: 1'b1, le: 1'b1, n_over: 0, n_eq: M, exp_miss: 0, exp_learned: 1'b1};

        repeat (3) @(posedge clock);
        #1;
        check("reset_ctrl",
              VW'({s_ready, busy, layer_valid, layer_learn, r_valid, r_learned}), VW'(0));
        check("reset_r_out", r_out, VW'(0));
        check("reset_r_miss", VW'(r_miss), VW'(0));
        check("reset_layer_in", VW'(layer_in), VW'(0));
`ifdef NEURON_SEQ_ERR_ACCUM_EN
        check("reset_err_sum", VW'(err_sum), VW'(0));
`endif
        reset = 1'b0;
        @(posedge clock); #1;
        check("post_reset_ready", VW'({s_ready, busy}), VW'(2'b10));

        for (int i = 0; i < 6; i++) begin
            build_directed(tbl[i].n_over, tbl[i].n_eq);
            do_sample(tbl[i].lrn, tbl[i].le, tbl[i].exp_miss,
                      tbl[i].exp_learned, 0, 1'b0, 1'b0);
        end

        build_directed(4, 2);
        do_sample(1'b0, 1'b0, 4, 1'b0, 10, 1'b1, 1'b0);
        build_directed(1, 0);
        do_sample(1'b1, 1'b1, 1, 1'b1, 0, 1'b0, 1'b0);

        for (int i = 0; i < 20; i++) begin
            bit lrn, le, early;
            int rd;
            lrn   = 1'($urandom_range(0, 1));
            le    = 1'($urandom_range(0, 1));
            early = 1'($urandom_range(0, 1));
            rd    = int'($urandom_range(0, 3));
            build_random();
            do_sample(lrn, le, ref_miss(), lrn & le, rd, 1'b0, early);
        end

        abort_run(1);
        abort_run(5);

        build_directed(3, 3);
        do_sample(1'b1, 1'b1, 3, 1'b1, 0, 1'b0, 1'b0);

`ifdef NEURON_SEQ_ERR_ACCUM_EN
        err_clear = 1'b1;
        @(posedge clock); #1;
        err_clear = 1'b0;
        err_model = 0;
        check("err_clear", VW'(err_sum), VW'(0));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
